// File: rtl/serial_add_sub_32.sv
// Bit-serial adder/subtractor: one full-adder cell (two half adders plus an OR)
// processes one bit per clock, with the carry held in a flip-flop between bits.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_sub_32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             V,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] s_sh;
    logic             c, c_msb;
    logic [CW-1:0]    cnt;

    logic p, g0, s, g1, cout;

    half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(p), .c(g0));
    half_adder u_ha1 (.x(p),       .y(c),       .s(s), .c(g1));
    assign cout = g0 | g1;

    // c_msb and CO are both captured on the completion edge, so V holds with them.
    assign V = c_msb ^ CO;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            c_msb <= 1'b0;
            cnt   <= '0;
            Y     <= '0;
            CO    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        // Subtract as A + ~B + 1.
                        a_sh  <= A;
                        b_sh  <= B ^ {WIDTH{SnA}};
                        c     <= SnA;
                        cnt   <= '0;
                        state <= ST_RUN;
                        BUSY  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    s_sh <= {s, s_sh[WIDTH-2:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= cout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        c_msb <= c;
                        Y     <= {s, s_sh};
                        CO    <= cout;
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub_32.sv
// Bench for serial_add_sub_32: per-cycle compare against an arithmetic model,
// plus directed literal checks and randomized operations.

module tb_serial_add_sub_32;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         START = 1'b0;
    logic         SnA = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Y;
    logic         CO, V, BUSY, DONE;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    serial_add_sub_32 #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SnA(SnA), .A(A), .B(B),
        .Y(Y), .CO(CO), .V(V), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: result from plain arithmetic, timing from a countdown.
    logic [W-1:0] m_y = '0, p_y = '0;
    logic         m_co = 0, m_v = 0, p_co = 0, p_v = 0;
    logic         m_busy = 0, m_done = 0;
    int           rem = 0;

    function automatic void arith(input logic [W-1:0] a, b, input logic sna,
                                  output logic [W-1:0] y, output logic co, v);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, (sna ? ~b : b)} + {{W{1'b0}}, sna};
        y   = sum[W-1:0];
        co  = sum[W];
        if (sna) v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
        else     v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_busy = 0; m_done = 0; m_y = '0; m_co = 0; m_v = 0; rem = 0;
        end else if (m_busy) begin
            rem--;
            if (rem == 0) begin
                m_busy = 0; m_done = 1; m_y = p_y; m_co = p_co; m_v = p_v;
            end
        end else begin
            m_done = 0;
            if (START) begin
                arith(A, B, SnA, p_y, p_co, p_v);
                m_busy = 1;
                rem = W;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy", 64'(BUSY), 64'(m_busy));
            chk("done", 64'(DONE), 64'(m_done));
            chk("y",    64'(Y),    64'(m_y));
            chk("co",   64'(CO),   64'(m_co));
            chk("v",    64'(V),    64'(m_v));
        end
    end

    // Caller is positioned 1 time unit after a rising edge; returns inside the DONE cycle.
    task automatic do_op(input logic [W-1:0] a, b, input logic sna, input bit lit,
                         input logic [W-1:0] ey, input logic eco, ev, input bit interfere);
        int n;
        A = a; B = b; SnA = sna; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = $urandom; B = $urandom; SnA = 1'($urandom);
        n = 0;
        while (!DONE && n < 40) begin
            if (interfere && n == 9) begin
                START = 1'b1; A = 32'hAAAAAAAA; B = 32'hAAAAAAAA;
            end else if (interfere && n == 10) begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            n++;
        end
        if (!DONE) $display("FAIL timeout: no done after %0d cycles, expected 32", n);
        chk("latency", 64'(n), 64'd32);
        if (lit) begin
            chk("lit_y",  64'(Y),  64'(ey));
            chk("lit_co", 64'(CO), 64'(eco));
            chk("lit_v",  64'(V),  64'(ev));
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge CLK); #1; end
    endtask

    initial begin
        int t1, dones;
        logic [W-1:0] ra, rb;
        logic [W-1:0] edges [6];
        edges = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hAAAAAAAA};

        RST = 1'b0;
        idle(3);
        chk_en = 1;
        RST = 1'b1;
        chk("rst_y", 64'(Y), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        idle(2);

        do_op(32'd5, 32'd3, 1'b0, 1, 32'h8, 1'b0, 1'b0, 0);
        idle(1);
        do_op(32'hFFFFFFFF, 32'h1, 1'b0, 1, 32'h0, 1'b1, 1'b0, 0);
        idle(2);
        do_op(32'd3, 32'd5, 1'b1, 1, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
        idle(1);
        do_op(32'd5, 32'd3, 1'b1, 1, 32'h2, 1'b1, 1'b0, 0);
        idle(1);
        do_op(32'h7FFFFFFF, 32'h1, 1'b0, 1, 32'h80000000, 1'b0, 1'b1, 0);
        idle(1);
        do_op(32'h80000000, 32'h1, 1'b1, 1, 32'h7FFFFFFF, 1'b1, 1'b1, 0);
        idle(1);
        do_op(32'd5, 32'd3, 1'b0, 1, 32'h8, 1'b0, 1'b0, 1);
        idle(2);

        // Abort mid-run with a one-cycle reset pulse.
        A = 32'd100; B = 32'd23; SnA = 1'b0; START = 1'b1;
        idle(1);
        START = 1'b0;
        idle(15);
        RST = 1'b0;
        #2;
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        chk("abort_y",    64'(Y),    64'd0);
        chk("abort_co",   64'(CO),   64'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge CLK); #1; if (DONE) dones++; end
        chk("abort_no_done", 64'(dones), 64'd0);

        // Back-to-back: second START issued during the DONE cycle.
        do_op(32'd5, 32'd3, 1'b0, 1, 32'h8, 1'b0, 1'b0, 0);
        t1 = cyc;
        do_op(32'd1, 32'd2, 1'b0, 1, 32'h3, 1'b0, 1'b0, 0);
        chk("b2b_gap", 64'(cyc - t1), 64'd33);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : W'($urandom);
            do_op(ra, rb, 1'($urandom), 0, '0, 1'b0, 1'b0, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        idle(3);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
